// File: rtl/uart_tx.sv
// UART transmitter: takes one word over valid/ready and sends it on tx_pin as
// start bit, LSB-first data, optional parity bit, then one or two stop bits.
module uart_tx #(
  parameter int unsigned Challenge_Bit     = 8,
  parameter int unsigned frequency_clk_ref = 100,
  parameter int unsigned BAUD_RATE         = 115200,
  parameter int unsigned PARITY            = 0,
  parameter int unsigned STOP_BITS         = 1
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [Challenge_Bit-1:0] tx_data,
  input  logic                     tx_data_valid,
  output logic                     tx_data_ready,
  output logic                     tx_busy,
  output logic                     tx_pin
);

  localparam int unsigned CYCLE = (frequency_clk_ref * 1000000) / BAUD_RATE;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = $clog2(Challenge_Bit);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(Challenge_Bit - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                   state, state_nx;
  logic [CNT_W-1:0]         cycle_cnt, cycle_cnt_nx;
  logic [BIT_W-1:0]         bit_cnt, bit_cnt_nx;
  logic [Challenge_Bit-1:0] shift_q, shift_nx;
  logic                     parity_q, parity_nx;
  logic                     tx_pin_nx;
  logic                     ready_nx;
  logic                     bit_end;
  logic                     accept;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_nx     = state;
    cycle_cnt_nx = cycle_cnt + CNT_W'(1);
    bit_cnt_nx   = bit_cnt;
    shift_nx     = shift_q;
    parity_nx    = parity_q;
    tx_pin_nx    = 1'b1;
    bit_end      = (cycle_cnt == CNT_LAST);
    accept       = tx_data_valid && tx_data_ready;

    case (state)
      S_IDLE: begin
        cycle_cnt_nx = '0;
        bit_cnt_nx   = '0;
      end
      S_START: begin
        tx_pin_nx = 1'b0;
        if (bit_end) begin
          state_nx     = S_DATA;
          cycle_cnt_nx = '0;
          bit_cnt_nx   = '0;
          tx_pin_nx    = shift_q[0];
        end
      end
      S_DATA: begin
        tx_pin_nx = shift_q[0];
        if (bit_end) begin
          cycle_cnt_nx = '0;
          shift_nx     = shift_q >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nx = '0;
            if (PARITY != 0) begin
              state_nx  = S_PARITY;
              tx_pin_nx = parity_q;
            end else begin
              state_nx  = S_STOP;
              tx_pin_nx = 1'b1;
            end
          end else begin
            bit_cnt_nx = bit_cnt + BIT_W'(1);
            tx_pin_nx  = shift_nx[0];
          end
        end
      end
      S_PARITY: begin
        tx_pin_nx = parity_q;
        if (bit_end) begin
          state_nx     = S_STOP;
          cycle_cnt_nx = '0;
          tx_pin_nx    = 1'b1;
        end
      end
      S_STOP: begin
        tx_pin_nx = 1'b1;
        if (bit_end) begin
          cycle_cnt_nx = '0;
          if (bit_cnt == STOP_LAST) begin
            state_nx   = S_IDLE;
            bit_cnt_nx = '0;
          end else begin
            bit_cnt_nx = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_nx     = S_IDLE;
        cycle_cnt_nx = '0;
        bit_cnt_nx   = '0;
        tx_pin_nx    = 1'b1;
      end
    endcase

    // ready is only high in idle or on the final stop clock, so a new word starts with no gap
    if (accept && (state == S_IDLE || state == S_STOP)) begin
      state_nx     = S_START;
      cycle_cnt_nx = '0;
      bit_cnt_nx   = '0;
      shift_nx     = tx_data;
      tx_pin_nx    = 1'b0;
      if (PARITY == 1)
        parity_nx = ~(^tx_data);
      else if (PARITY == 2)
        parity_nx = ^tx_data;
      else
        parity_nx = 1'b0;
    end

    ready_nx = (state_nx == S_IDLE) ||
               ((state_nx == S_STOP) && (cycle_cnt_nx == CNT_LAST) && (bit_cnt_nx == STOP_LAST));
  end

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Counters, shift register and registered outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cycle_cnt     <= '0;
      bit_cnt       <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tx_pin        <= 1'b1;
      tx_data_ready <= 1'b1;
      tx_busy       <= 1'b0;
    end else begin
      cycle_cnt     <= cycle_cnt_nx;
      bit_cnt       <= bit_cnt_nx;
      shift_q       <= shift_nx;
      parity_q      <= parity_nx;
      tx_pin        <= tx_pin_nx;
      tx_data_ready <= ready_nx;
      tx_busy       <= ~ready_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four differently parameterised instances, each with a
// driver pushing expected words and a monitor decoding tx_pin against a frame model.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int NLANE     = 4;
  localparam int NW_RANDOM = 40;
  localparam int RUN_LIMIT = 90000;

  typedef struct packed {
    logic [15:0] data;
    logic        abort;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cb_of(input int g);
    case (g) 0: return 8; 1: return 5; 2: return 16; default: return 8; endcase
  endfunction
  function automatic int freq_of(input int g);
    case (g) 0: return 100; 1: return 1; 2: return 1; default: return 2; endcase
  endfunction
  function automatic int baud_of(input int g);
    case (g) 0: return 115200; 1: return 333333; 2: return 142857; default: return 400000; endcase
  endfunction
  function automatic int par_of(input int g);
    case (g) 0: return 0; 1: return 1; 2: return 2; default: return 2; endcase
  endfunction
  function automatic int stop_of(input int g);
    case (g) 0: return 1; 1: return 2; 2: return 1; default: return 2; endcase
  endfunction

  // Reference frame as a line-level bit list, index 0 = first bit on the wire
  function automatic logic [31:0] frame_of(input logic [15:0] d, input int cb, input int par);
    logic [31:0] f;
    int          ones;
    f    = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < cb; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (par == 1) f[1+cb] = (ones % 2 == 0);
    if (par == 2) f[1+cb] = (ones % 2 == 1);
    return f;
  endfunction

  task automatic check(input string name, input logic ok, input string detail);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  for (genvar g = 0; g < NLANE; g++) begin : lane
    localparam int CB   = cb_of(g);
    localparam int PAR  = par_of(g);
    localparam int STOP = stop_of(g);
    localparam int CYC  = freq_of(g) * 1000000 / baud_of(g);
    localparam int NB   = 1 + CB + ((PAR != 0) ? 1 : 0) + STOP;
    localparam int FLEN = NB * CYC;
    localparam int WAIT_LIM = FLEN + 200;

    logic          n_reset;
    logic [CB-1:0] tx_data;
    logic          tx_data_valid;
    logic          tx_data_ready;
    logic          tx_busy;
    logic          tx_pin;

    exp_t        q[$];
    int unsigned acc_q[$];
    bit          drv_done = 0;
    bit          prev_ok = 0;
    int unsigned prev_acc = 0;

    uart_tx #(
      .Challenge_Bit    (CB),
      .frequency_clk_ref(freq_of(g)),
      .BAUD_RATE        (baud_of(g)),
      .PARITY           (PAR),
      .STOP_BITS        (STOP)
    ) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .tx_data      (tx_data),
      .tx_data_valid(tx_data_valid),
      .tx_data_ready(tx_data_ready),
      .tx_busy      (tx_busy),
      .tx_pin       (tx_pin)
    );

    // Called at a falling edge; returns at the falling edge after the accept edge
    task automatic send(input logic [15:0] d, input bit abort_it);
      int unsigned now;
      int unsigned exp_acc;
      int unsigned acc;
      int          n;
      exp_t        e;
      now     = cyc;
      exp_acc = (prev_ok && (prev_acc + FLEN > now + 1)) ? prev_acc + FLEN : now + 1;
      e.data  = d & 16'((32'd1 << CB) - 1);
      e.abort = abort_it;
      q.push_back(e);
      tx_data       = CB'(d);
      tx_data_valid = 1'b1;
      n = 0;
      while (tx_data_ready !== 1'b1 && n < 2 * FLEN + 10) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("lane%0d_ready_seen", g), tx_data_ready === 1'b1,
            $sformatf("got ready=%b, required 1 within %0d clocks", tx_data_ready, 2 * FLEN + 10));
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      acc_q.push_back(acc);
      tx_data_valid = 1'b0;
      tx_data       = CB'($urandom);
      check($sformatf("lane%0d_accept_time", g), acc == exp_acc,
            $sformatf("got accept at clock %0d, required %0d", acc, exp_acc));
      prev_ok  = 1'b1;
      prev_acc = acc;
    endtask

    // Driver
    initial begin
      n_reset       = 1'b0;
      tx_data       = '0;
      tx_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("lane%0d_reset_state", g),
            tx_pin === 1'b1 && tx_data_ready === 1'b1 && tx_busy === 1'b0,
            $sformatf("got pin/ready/busy=%b%b%b, required 110", tx_pin, tx_data_ready, tx_busy));
      @(negedge clk);
      n_reset = 1'b1;
      repeat (2) @(negedge clk);
      if (g == 0) begin
        send(16'h55, 1'b0);
        repeat (FLEN + 20) @(negedge clk);
        send(16'hA3, 1'b0);
        send(16'h0F, 1'b0);
        repeat (FLEN + 20) @(negedge clk);
        send(16'hC5, 1'b1);
        repeat (2999) @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("lane0_async_reset",
              tx_pin === 1'b1 && tx_data_ready === 1'b1 && tx_busy === 1'b0,
              $sformatf("got pin/ready/busy=%b%b%b, required 110", tx_pin, tx_data_ready, tx_busy));
        repeat (5) @(negedge clk);
        n_reset = 1'b1;
        prev_ok = 1'b0;
        repeat (3) @(negedge clk);
        send(16'h3C, 1'b0);
        repeat (FLEN + 20) @(negedge clk);
        send(16'h96, 1'b0);
        repeat (20) begin
          tx_data       = CB'($urandom);
          tx_data_valid = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        tx_data_valid = 1'b0;
        repeat (FLEN + 20) @(negedge clk);
      end else begin
        for (int i = 0; i < NW_RANDOM; i++) begin
          logic [15:0] d;
          d = 16'($urandom);
          if (i == 0) d = 16'h0007;
          if (i == 1) d = 16'hFFFF;
          send(d, 1'b0);
          repeat ($urandom_range(0, FLEN + 4)) @(negedge clk);
        end
        repeat (FLEN + 10) @(negedge clk);
      end
      drv_done = 1'b1;
    end

    // Monitor: capture each frame on tx_pin and score it against the queue
    initial begin
      bit fin;
      fin = 1'b0;
      while (!fin) begin : frame
        int          w;
        int unsigned st;
        int unsigned a;
        int          bad_hold;
        int          bad_hs;
        bit          got;
        bit          ab;
        logic [31:0] obs;
        logic [31:0] expf;
        logic [31:0] mask;
        exp_t        e;
        w   = 0;
        got = 1'b0;
        while (!got && w < WAIT_LIM) begin
          @(negedge clk);
          w++;
          got = (n_reset === 1'b1 && tx_pin === 1'b0);
        end
        if (!got) begin
          check($sformatf("lane%0d_idle_end", g), drv_done && q.size() == 0,
                $sformatf("got drv_done=%0d pending=%0d, required drv_done=1 pending=0", drv_done, q.size()));
          fin = 1'b1;
        end else begin
          st       = cyc;
          ab       = 1'b0;
          bad_hold = 0;
          bad_hs   = 0;
          obs      = '1;
          for (int s = 0; s < FLEN; s++) begin
            if (s > 0) @(negedge clk);
            if (n_reset !== 1'b1) begin
              ab = 1'b1;
              break;
            end
            if (s % CYC == 0) obs[s / CYC] = tx_pin;
            else if (tx_pin !== obs[s / CYC]) bad_hold++;
            if (tx_data_ready !== (s == FLEN - 1) || tx_busy !== (s != FLEN - 1)) bad_hs++;
          end
          check($sformatf("lane%0d_expected_frame", g), q.size() != 0 && acc_q.size() != 0,
                $sformatf("got a frame with %0d words pending, required at least 1", q.size()));
          if (q.size() != 0 && acc_q.size() != 0) begin
            e = q.pop_front();
            a = acc_q.pop_front();
            check($sformatf("lane%0d_start_time", g), st == a,
                  $sformatf("got start bit at clock %0d, required %0d", st, a));
            check($sformatf("lane%0d_abort", g), ab == e.abort,
                  $sformatf("got aborted=%0d, required %0d (data %h)", ab, e.abort, e.data));
            if (!ab && !e.abort) begin
              expf = frame_of(e.data, CB, PAR);
              mask = (NB >= 32) ? '1 : ((32'd1 << NB) - 1);
              check($sformatf("lane%0d_frame", g), (obs & mask) === (expf & mask),
                    $sformatf("data %h: got bits %h, required %h", e.data, obs & mask, expf & mask));
              check($sformatf("lane%0d_bit_hold", g), bad_hold == 0,
                    $sformatf("got %0d mid-bit changes, required 0", bad_hold));
              check($sformatf("lane%0d_handshake", g), bad_hs == 0,
                    $sformatf("got %0d bad ready/busy samples, required 0", bad_hs));
            end
          end
        end
      end
      done_cnt++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (done_cnt < NLANE && t < RUN_LIMIT) begin
      @(posedge clk);
      t++;
    end
    check("run_complete", done_cnt == NLANE,
          $sformatf("got %0d lanes finished, required %0d", done_cnt, NLANE));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
